switch_port_irq: RTL and testbench
==================================

// Module: switch_port_irq
// PURPOSE
//   Parametrised debounced switch/button input port on the 4-way handshake data bus.
//   - Per-channel synchroniser and debounce filter.
//   - Edge-capture (pending) register with write-1-to-clear.
//   - Interrupt-mask register and a registered level interrupt to the CPU.
//   Sits between the physical board inputs and the MIPS32 memory-mapped I/O decoder.
// PARAMETERS
//   WIDTH            8        number of input channels (1..32)
//   DEBOUNCE_CYCLES  50000    consecutive stable samples needed to accept a new level (>=2)
//   CNT_W            16       debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES
// PORTS
//   clock      in   1      single system clock
//   reset      in   1      synchronous, active-high reset
//   Read       in   1      bus read strobe, held until Ack seen
//   Write      in   1      bus write strobe, held until Ack seen
//   Address    in   2      register select: 0=STATE, 1=PENDING, 2=MASK, 3=reserved
//   DataIn     in   WIDTH  write data
//   Switch_in  in   WIDTH  raw asynchronous physical inputs
//   Ack        out  1      bus acknowledge
//   DataOut    out  WIDTH  read data, valid while Ack=1
//   Switch_out out  WIDTH  debounced level (STATE register)
//   Irq        out  1      level interrupt: |(PENDING & MASK), registered
// BEHAVIOUR
//   Reset values: Ack=0, DataOut=0, Switch_out=0, PENDING=0, MASK=0, Irq=0.
//   Reset also clears synchroniser flops and all debounce counters. A debounce in progress is discarded.
//   Synchroniser: 2 flops per channel; sync = second flop.
//   Debounce (per channel, counter cnt):
//     - sync==stable: cnt<=0.
//     - sync!=stable and cnt==DEBOUNCE_CYCLES-1: stable<=sync, cnt<=0.
//     - otherwise cnt<=cnt+1.
//     - Any glitch back to the stable level restarts the count from 0.
//     - Pin-to-Switch_out latency: DEBOUNCE_CYCLES+2 clocks.
//   Edge detect: rise[i] = stable[i] 0->1 in this cycle. Sets PENDING[i] on the following edge.
//   Bus handshake:
//     - Ack <= reset ? 0 : (Read|Write).
//     - Ack falls one clock after the strobe drops.
//     - Read and Write both high: treated as Write, DataOut=0.
//   Read: DataOut <= selected register each cycle Read=1; DataOut <= 0 when Read=0. Address 3 reads 0.
//   Write, applied each cycle Write=1 (idempotent):
//     - Addr 1: PENDING &= ~DataIn (W1C).
//     - Addr 2: MASK <= DataIn.
//     - Addr 0 and 3: ignored.
//   Simultaneous W1C and new edge on the same bit: set wins, bit stays 1.
//   Irq <= |(PENDING & MASK). It follows the register update by one clock.
//     - Clearing PENDING or MASK drops Irq one clock later.
//     - Writing MASK while pending bits exist raises Irq one clock later.
//   Counters saturate by construction: cnt never exceeds DEBOUNCE_CYCLES-1, no wrap.
// CONFIGURATION
//   SWITCH_PORT_FALLING_EDGE_EN
//     - Defined: PENDING[i] is also set on a stable 1->0 transition (both edges captured).
//     - Undefined: only rising edges set PENDING; falling edges affect STATE only.
//   Register map and timing are identical either way.
// TESTING (bench: WIDTH=4, DEBOUNCE_CYCLES=4)
//   1. Reset held 3 clocks with Switch_in=4'hF -> all outputs 0. Switch_out=4'hF exactly 6 clocks after reset release.
//   2. Switch_in[0] pulses high for 3 clocks, then low -> Switch_out[0] stays 0, PENDING stays 0.
//   3. MASK<=4'h1, then Switch_in[0] goes 0->1 and is held -> PENDING=4'h1, Irq=1.
//      W1C Addr1 DataIn=4'h1 -> PENDING=0 and Irq=0 one clock later.
//   4. Read held 5 clocks at Addr0 with Switch_out=4'hA -> Ack rises 1 clock after Read, DataOut=4'hA.
//      Ack falls 1 clock after Read drops.
//   5. W1C of bit 1 in the same cycle bit 1 rises -> PENDING[1] remains 1.
//   6. Switch_in[2] goes 1->0 after settling -> PENDING[2]=1 only with SWITCH_PORT_FALLING_EDGE_EN defined, else 0.

Source files
------------

// File: rtl/switch_port_irq.sv
`default_nettype none
// ============================================================================
// Module      : switch_port_irq
// Description : Debounced switch/button input port with edge-capture pending
//               register, interrupt mask and level interrupt on the 4-way
//               handshake bus. Optional macro SWITCH_PORT_FALLING_EDGE_EN
//               also captures stable 1->0 transitions into PENDING.
// Revision    : 1.0 - initial release
// ============================================================================
module switch_port_irq #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             Read,
  input  logic             Write,
  input  logic [1:0]       Address,
  input  logic [WIDTH-1:0] DataIn,
  input  logic [WIDTH-1:0] Switch_in,
  output logic             Ack,
  output logic [WIDTH-1:0] DataOut,
  output logic [WIDTH-1:0] Switch_out,
  output logic             Irq
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] c_ADDR_STATE   = 2'd0;
  localparam logic [1:0] c_ADDR_PENDING = 2'd1;
  localparam logic [1:0] c_ADDR_MASK    = 2'd2;

  logic [WIDTH-1:0] stable_w;
  logic [WIDTH-1:0] stable_dly_q;
  logic [WIDTH-1:0] pending_q;
  logic [WIDTH-1:0] pending_d;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] edge_w;
  logic [WIDTH-1:0] clr_w;
  logic [WIDTH-1:0] rdata_w;
  logic [WIDTH-1:0] dataout_q;
  logic             ack_q;
  logic             irq_q;

  // Each channel: two-flop synchroniser feeding a restartable stability counter
  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clock) begin
      if (reset) begin
        sync1_q  <= 1'b0;
        sync2_q  <= 1'b0;
        stable_q <= 1'b0;
        cnt_q    <= '0;
      end else begin
        sync1_q <= Switch_in[i];
        sync2_q <= sync1_q;
        if (sync2_q == stable_q) begin
          cnt_q <= '0;
        end else if (cnt_q == c_CNT_MAX) begin
          stable_q <= sync2_q;
          cnt_q    <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end

    assign stable_w[i] = stable_q;
  end

`ifdef SWITCH_PORT_FALLING_EDGE_EN
  assign edge_w = stable_w ^ stable_dly_q;
`else
  assign edge_w = stable_w & ~stable_dly_q;
`endif

  assign clr_w = (Write && (Address == c_ADDR_PENDING)) ? DataIn : '0;

  // A new edge wins over a simultaneous write-1-to-clear of the same bit
  always_comb begin
    pending_d = (pending_q & ~clr_w) | edge_w;
  end

  always_comb begin
    rdata_w = '0;
    case (Address)
      c_ADDR_STATE:   rdata_w = stable_w;
      c_ADDR_PENDING: rdata_w = pending_q;
      c_ADDR_MASK:    rdata_w = mask_q;
      default:        rdata_w = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stable_dly_q <= '0;
      pending_q    <= '0;
      mask_q       <= '0;
      dataout_q    <= '0;
      ack_q        <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      stable_dly_q <= stable_w;
      pending_q    <= pending_d;
      if (Write && (Address == c_ADDR_MASK)) begin
        mask_q <= DataIn;
      end
      // Read together with Write behaves as a write and returns zero
      dataout_q <= (Read && !Write) ? rdata_w : '0;
      ack_q     <= Read | Write;
      irq_q     <= |(pending_q & mask_q);
    end
  end

  assign Ack        = ack_q;
  assign DataOut    = dataout_q;
  assign Switch_out = stable_w;
  assign Irq        = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_switch_port_irq.sv
`default_nettype none
// ============================================================================
// Module      : tb_switch_port_irq
// Description : Directed self-checking bench for switch_port_irq
//               (WIDTH=4, DEBOUNCE_CYCLES=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_port_irq;

  logic       clock;
  logic       reset;
  logic       Read;
  logic       Write;
  logic [1:0] Address;
  logic [3:0] DataIn;
  logic [3:0] Switch_in;
  logic       Ack;
  logic [3:0] DataOut;
  logic [3:0] Switch_out;
  logic       Irq;

  int n_cmp = 0;
  int n_err = 0;

  switch_port_irq #(
    .WIDTH          (4),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .Read      (Read),
    .Write     (Write),
    .Address   (Address),
    .DataIn    (DataIn),
    .Switch_in (Switch_in),
    .Ack       (Ack),
    .DataOut   (DataOut),
    .Switch_out(Switch_out),
    .Irq       (Irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_read(input logic [1:0] addr, output logic [3:0] data);
    Address = addr;
    Read    = 1'b1;
    tick();
    check("rd_ack", 32'(Ack), 32'd1);
    data = DataOut;
    Read = 1'b0;
    tick();
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [3:0] data);
    Address = addr;
    DataIn  = data;
    Write   = 1'b1;
    tick();
    Write = 1'b0;
    tick();
  endtask

  task automatic settle();
    repeat (8) tick();
  endtask

  logic [3:0] rd;

  initial begin
    reset     = 1'b1;
    Read      = 1'b0;
    Write     = 1'b0;
    Address   = 2'd0;
    DataIn    = 4'h0;
    Switch_in = 4'hF;

    // 1: reset state and power-up latency
    repeat (3) tick();
    check("rst_ack", 32'(Ack), 32'd0);
    check("rst_dout", 32'(DataOut), 32'h0);
    check("rst_swout", 32'(Switch_out), 32'h0);
    check("rst_irq", 32'(Irq), 32'd0);
    reset = 1'b0;
    repeat (5) tick();
    check("lat_5", 32'(Switch_out), 32'h0);
    tick();
    check("lat_6", 32'(Switch_out), 32'hF);
    tick();
    bus_read(2'd1, rd);
    check("pend_after_rise", 32'(rd), 32'hF);
    check("irq_masked", 32'(Irq), 32'd0);
    Switch_in = 4'h0;
    settle();
    bus_write(2'd1, 4'hF);
    bus_read(2'd1, rd);
    check("pend_cleared", 32'(rd), 32'h0);

    // 2: glitch shorter than the debounce window is rejected
    Switch_in = 4'h1;
    repeat (3) tick();
    Switch_in = 4'h0;
    settle();
    check("glitch_swout", 32'(Switch_out), 32'h0);
    bus_read(2'd1, rd);
    check("glitch_pend", 32'(rd), 32'h0);

    // 3: masked rising edge raises Irq; W1C drops it one clock later
    bus_write(2'd2, 4'h1);
    bus_read(2'd2, rd);
    check("mask_rd", 32'(rd), 32'h1);
    Switch_in = 4'h1;
    repeat (6) tick();
    check("t3_swout", 32'(Switch_out), 32'h1);
    tick();
    check("t3_irq_early", 32'(Irq), 32'd0);
    tick();
    check("t3_irq", 32'(Irq), 32'd1);
    bus_read(2'd1, rd);
    check("t3_pend", 32'(rd), 32'h1);
    Address = 2'd1;
    DataIn  = 4'h1;
    Write   = 1'b1;
    tick();
    Write = 1'b0;
    check("w1c_irq_same", 32'(Irq), 32'd1);
    tick();
    check("w1c_irq_drop", 32'(Irq), 32'd0);
    bus_read(2'd1, rd);
    check("w1c_pend", 32'(rd), 32'h0);

    // 4: held read of STATE
    Switch_in = 4'hA;
    settle();
    check("t4_ack_idle", 32'(Ack), 32'd0);
    Address = 2'd0;
    Read    = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t4_ack", 32'(Ack), 32'd1);
      check("t4_dout", 32'(DataOut), 32'hA);
    end
    Read = 1'b0;
    tick();
    check("t4_ack_fall", 32'(Ack), 32'd0);
    check("t4_dout_zero", 32'(DataOut), 32'h0);
    bus_write(2'd2, 4'h0);
    bus_write(2'd1, 4'hF);
    tick();
    check("t4_irq_off", 32'(Irq), 32'd0);

    // Read and Write together act as a write and return zero
    Address = 2'd2;
    DataIn  = 4'h5;
    Read    = 1'b1;
    Write   = 1'b1;
    tick();
    check("rw_ack", 32'(Ack), 32'd1);
    check("rw_dout", 32'(DataOut), 32'h0);
    Read  = 1'b0;
    Write = 1'b0;
    tick();
    bus_read(2'd2, rd);
    check("rw_mask", 32'(rd), 32'h5);
    bus_write(2'd2, 4'h0);
    bus_read(2'd3, rd);
    check("addr3_zero", 32'(rd), 32'h0);

    // 5: W1C of bit 1 coinciding with its rising edge
    Switch_in = 4'h8;
    settle();
    bus_write(2'd1, 4'hF);
    Switch_in = 4'hA;
    repeat (6) tick();
    check("t5_swout", 32'(Switch_out), 32'hA);
    Address = 2'd1;
    DataIn  = 4'h2;
    Write   = 1'b1;
    tick();
    Write = 1'b0;
    tick();
    bus_read(2'd1, rd);
    check("t5_set_wins", 32'(rd), 32'h2);
    // Unmasking an already-pending bit raises Irq one clock later
    Address = 2'd2;
    DataIn  = 4'h2;
    Write   = 1'b1;
    tick();
    Write = 1'b0;
    check("mask_irq_same", 32'(Irq), 32'd0);
    tick();
    check("mask_irq_rise", 32'(Irq), 32'd1);
    bus_write(2'd1, 4'h2);
    bus_read(2'd1, rd);
    check("t5_w1c", 32'(rd), 32'h0);
    check("t5_irq_off", 32'(Irq), 32'd0);
    bus_write(2'd2, 4'h0);

    // 6: falling edge on bit 2
    Switch_in = 4'hE;
    settle();
    bus_write(2'd1, 4'hF);
    Switch_in = 4'hA;
    settle();
    check("t6_swout", 32'(Switch_out), 32'hA);
    bus_read(2'd1, rd);
`ifdef SWITCH_PORT_FALLING_EDGE_EN
    check("t6_fall_pend", 32'(rd), 32'h4);
`else
    check("t6_fall_pend", 32'(rd), 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
